// File: rtl/qtcore_dbg_pkg.sv
// Shared definitions for the qtcore multi-chain debug port.
// Holds the FSM state encoding and the default parameter values used by
// qtcore_debug_port and its testbench.
package qtcore_dbg_pkg;

   localparam int unsigned DEF_NUM_CHAINS = 4;
   localparam int unsigned DEF_SEL_W      = 2;
   localparam int unsigned DEF_CNT_W      = 16;

   typedef enum logic [2:0] {
      StWait   = 3'd0,
      StIdle   = 3'd1,
      StSel    = 3'd2,
      StShift  = 3'd3,
      StBadsel = 3'd4,
      StRun    = 3'd5,
      StHalted = 3'd6
   } dbg_state_t;

endpackage

// File: rtl/dbg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the count
//   clear  - synchronous clear (lower priority than rst)
//   enable - increment by one, holding at all-ones
//   count  - current count value
module dbg_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/qtcore_debug_port.sv
// Multi-chain SPI-style scan/run debug front end for the accumulator core.
// A scan transfer begins with an SEL_W-bit chain-select header (MSB first);
// the rest of the transfer is routed to the selected scan chain. A run
// transfer gates the processor enable and latches a sticky halt flag.
// Ports:
//   clk, rst        - shared clock, synchronous active-high reset
//   scan_cs_n       - active-low scan-transfer select
//   proc_cs_n       - active-low processor-run select
//   mosi, miso      - serial data in / out
//   chain_scan_en   - one-hot scan enable per chain
//   chain_scan_in   - scan data to all chains (mosi)
//   chain_scan_out  - scan data returned by each chain
//   proc_en         - processor enable
//   halt            - processor halt indication
//   halt_sticky     - latched halt, cleared by the next scan shift
//   shift_count     - bits shifted in the current or last scan transfer
//   run_count       - enabled cycles in the current or last run
module qtcore_debug_port
   import qtcore_dbg_pkg::*;
#(
   parameter int unsigned NUM_CHAINS = DEF_NUM_CHAINS,
   parameter int unsigned SEL_W      = DEF_SEL_W,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scan_cs_n,
   input  logic                  proc_cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic [NUM_CHAINS-1:0] chain_scan_en,
   output logic                  chain_scan_in,
   input  logic [NUM_CHAINS-1:0] chain_scan_out,
   output logic                  proc_en,
   input  logic                  halt,
   output logic                  halt_sticky,
   output logic [CNT_W-1:0]      shift_count,
   output logic [CNT_W-1:0]      run_count
);

   localparam int unsigned HDR_W = (SEL_W > 1) ? $clog2(SEL_W) : 1;
   localparam logic [SEL_W:0] NUM_CHAINS_W = (SEL_W + 1)'(NUM_CHAINS);

   dbg_state_t       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [HDR_W-1:0] hdr_q, hdr_d;
   logic             sticky_q, sticky_d;

   logic [SEL_W-1:0] sel_shifted;
   logic             sel_valid;
   logic             hdr_last;
   logic             shift_active;
   logic             clear_shift;
   logic             clear_run;

   assign sel_shifted = (sel_q << 1) | SEL_W'(mosi);
   assign sel_valid   = ({1'b0, sel_shifted} < NUM_CHAINS_W);
   assign hdr_last    = (hdr_q == HDR_W'(SEL_W - 1));

   // Enables are combinational so they drop in the same cycle the select
   // rises or halt asserts.
   assign shift_active = (state_q == StShift) && !scan_cs_n;
   assign proc_en      = (state_q == StRun) && !proc_cs_n && scan_cs_n && !halt;

   // Counters restart only when a new frame of their own kind begins.
   assign clear_shift = (state_q == StIdle) && !scan_cs_n;
   assign clear_run   = (state_q == StIdle) && scan_cs_n && !proc_cs_n;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      hdr_d    = hdr_q;
      sticky_d = sticky_q;
      unique case (state_q)
         // A select held low through reset must be released before any frame.
         StWait: begin
            if (scan_cs_n && proc_cs_n) state_d = StIdle;
         end
         StIdle: begin
            if (!scan_cs_n) begin
               state_d = StSel;
               hdr_d   = '0;
            end else if (!proc_cs_n) begin
               state_d = StRun;
            end
         end
         StSel: begin
            if (scan_cs_n) begin
               state_d = StIdle;
            end else begin
               sel_d = sel_shifted;
               hdr_d = hdr_q + 1'b1;
               if (hdr_last) state_d = sel_valid ? StShift : StBadsel;
            end
         end
         StShift: begin
            if (scan_cs_n) state_d = StIdle;
            else           sticky_d = 1'b0;
         end
         StBadsel: begin
            if (scan_cs_n) state_d = StIdle;
         end
         StRun: begin
            if (!scan_cs_n) begin
               state_d = StWait;
            end else if (proc_cs_n) begin
               state_d = StIdle;
            end else if (halt) begin
               state_d  = StHalted;
               sticky_d = 1'b1;
            end
         end
         StHalted: begin
            if (!scan_cs_n)     state_d = StWait;
            else if (proc_cs_n) state_d = StIdle;
         end
         default: state_d = StWait;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StWait;
         sel_q    <= '0;
         hdr_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         hdr_q    <= hdr_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      chain_scan_en = '0;
      miso          = 1'b0;
      unique case (state_q)
         StShift: begin
            for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
               if (sel_q == SEL_W'(i)) begin
                  chain_scan_en[i] = !scan_cs_n;
                  miso             = chain_scan_out[i];
               end
            end
         end
         StRun, StHalted: miso = halt | sticky_q;
         default: miso = 1'b0;
      endcase
   end

   assign chain_scan_in = mosi;
   assign halt_sticky   = sticky_q;

   dbg_sat_counter #(
      .CNT_W (CNT_W)
   ) u_shift_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_shift),
      .enable (shift_active),
      .count  (shift_count)
   );

   dbg_sat_counter #(
      .CNT_W (CNT_W)
   ) u_run_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_run),
      .enable (proc_en),
      .count  (run_count)
   );

endmodule

// File: tb/tb_qtcore_debug_port.sv
// Testbench for qtcore_debug_port. Two instances share all stimulus:
// dut_a uses the defaults (4 chains, 16-bit counters) and dut_b uses
// 3 chains with 4-bit counters for the bad-select and saturation cases.
// Expected values are queued by the stimulus and checked at the falling edge.
module tb_qtcore_debug_port;

   logic       clk = 1'b0;
   logic       rst, scan_cs_n, proc_cs_n, mosi, halt;
   logic [3:0] cso;

   logic        miso_a, sin_a, pen_a, stk_a;
   logic [3:0]  en_a;
   logic [15:0] sc_a, rc_a;
   logic        miso_b, sin_b, pen_b, stk_b;
   logic [2:0]  en_b;
   logic [3:0]  sc_b, rc_b;

   always #5 clk = ~clk;

   qtcore_debug_port #(.NUM_CHAINS(4), .SEL_W(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .scan_cs_n(scan_cs_n), .proc_cs_n(proc_cs_n),
      .mosi(mosi), .miso(miso_a), .chain_scan_en(en_a), .chain_scan_in(sin_a),
      .chain_scan_out(cso), .proc_en(pen_a), .halt(halt), .halt_sticky(stk_a),
      .shift_count(sc_a), .run_count(rc_a)
   );

   qtcore_debug_port #(.NUM_CHAINS(3), .SEL_W(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .scan_cs_n(scan_cs_n), .proc_cs_n(proc_cs_n),
      .mosi(mosi), .miso(miso_b), .chain_scan_en(en_b), .chain_scan_in(sin_b),
      .chain_scan_out(cso[2:0]), .proc_en(pen_b), .halt(halt), .halt_sticky(stk_b),
      .shift_count(sc_b), .run_count(rc_b)
   );

   localparam int S_MISO_A = 0, S_EN_A = 1, S_PEN_A = 2, S_STK_A = 3, S_SC_A = 4;
   localparam int S_RC_A = 5, S_SIN_A = 6, S_MISO_B = 7, S_EN_B = 8, S_PEN_B = 9;
   localparam int S_STK_B = 10, S_SC_B = 11, S_RC_B = 12, S_SIN_B = 13;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_MISO_A: return 32'(miso_a);
         S_EN_A:   return 32'(en_a);
         S_PEN_A:  return 32'(pen_a);
         S_STK_A:  return 32'(stk_a);
         S_SC_A:   return 32'(sc_a);
         S_RC_A:   return 32'(rc_a);
         S_SIN_A:  return 32'(sin_a);
         S_MISO_B: return 32'(miso_b);
         S_EN_B:   return 32'(en_b);
         S_PEN_B:  return 32'(pen_b);
         S_STK_B:  return 32'(stk_b);
         S_SC_B:   return 32'(sc_b);
         S_RC_B:   return 32'(rc_b);
         S_SIN_B:  return 32'(sin_b);
         default:  return 32'hdead_beef;
      endcase
   endfunction

   // Monitor: outputs are stable half a cycle after the driving edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] got;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         got = actual(e.sig);
         n_tests++;
         if (got !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", e.name, got, e.exp, $time);
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic p, input logic m,
                       input logic h, input logic [3:0] c);
      @(posedge clk);
      #1;
      rst       = r;
      scan_cs_n = s;
      proc_cs_n = p;
      mosi      = m;
      halt      = h;
      cso       = c;
   endtask

   task automatic chk(input string n, input int sig, input logic [31:0] v);
      sb.push_back('{n, sig, v});
   endtask

   logic [7:0] data;
   logic       d;

   initial begin
      rst = 1'b1; scan_cs_n = 1'b0; proc_cs_n = 1'b1; mosi = 1'b0; halt = 1'b0; cso = '0;

      // Reset with scan select held low, then released while select stays low.
      step(1, 0, 1, 0, 0, 4'h0);
      repeat (2) begin
         step(1, 0, 1, 0, 0, 4'h0);
         chk("rst_en", S_EN_A, 0);  chk("rst_sc", S_SC_A, 0); chk("rst_rc", S_RC_A, 0);
         chk("rst_stk", S_STK_A, 0); chk("rst_miso", S_MISO_A, 0); chk("rst_pen", S_PEN_A, 0);
      end
      step(0, 0, 1, 0, 0, 4'h0);
      repeat (5) begin
         step(0, 0, 1, 0, 0, 4'h0);
         chk("wait_en_a", S_EN_A, 0); chk("wait_en_b", S_EN_B, 0);
      end
      step(0, 1, 1, 0, 0, 4'h0);
      step(0, 1, 1, 0, 0, 4'h0);

      // Header 2'b10 then 8 data bits to chain 2.
      step(0, 0, 1, 0, 0, 4'h0);
      step(0, 0, 1, 1, 0, 4'hF); chk("sel_miso", S_MISO_A, 0); chk("sel_en", S_EN_A, 0);
      step(0, 0, 1, 0, 0, 4'hF); chk("sel_en2", S_EN_A, 0);
      data = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         d = data[7-i];
         step(0, 0, 1, d, 0, d ? 4'b0100 : 4'b1011);
         chk("sh_en_a", S_EN_A, 4'b0100); chk("sh_miso_a", S_MISO_A, 32'(d));
         chk("sh_cnt_a", S_SC_A, i);      chk("sh_en_b", S_EN_B, 3'b100);
         chk("sh_sin_a", S_SIN_A, 32'(d)); chk("sh_sin_b", S_SIN_B, 32'(d));
      end
      step(0, 1, 1, 0, 0, 4'h0); chk("desel_en", S_EN_A, 0); chk("desel_cnt", S_SC_A, 8);
      step(0, 1, 1, 0, 0, 4'h0); chk("idle_en", S_EN_A, 0); chk("idle_cnt", S_SC_A, 8);

      // Header 2'b11: chain 3 on dut_a, bad select on dut_b.
      step(0, 0, 1, 0, 0, 4'hF);
      step(0, 0, 1, 1, 0, 4'hF); chk("sel_miso_f", S_MISO_A, 0);
      step(0, 0, 1, 1, 0, 4'hF);
      repeat (4) begin
         step(0, 0, 1, 1, 0, 4'hF);
         chk("bad_en_b", S_EN_B, 0); chk("bad_miso_b", S_MISO_B, 0); chk("bad_cnt_b", S_SC_B, 0);
         chk("ch3_en_a", S_EN_A, 4'b1000); chk("ch3_miso_a", S_MISO_A, 1);
      end
      step(0, 1, 1, 0, 0, 4'h0); chk("bad_end_b", S_SC_B, 0); chk("ch3_cnt_a", S_SC_A, 4);
      step(0, 1, 1, 0, 0, 4'h0);

      // Run 5 cycles, then halt.
      step(0, 1, 0, 0, 0, 4'h0); chk("idle_pen", S_PEN_A, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 0, 4'h0);
         chk("run_pen", S_PEN_A, 1); chk("run_cnt", S_RC_A, i); chk("run_miso", S_MISO_A, 0);
      end
      step(0, 1, 0, 0, 1, 4'h0);
      chk("halt_pen", S_PEN_A, 0); chk("halt_rc", S_RC_A, 5); chk("halt_miso", S_MISO_A, 1);
      chk("halt_stk0", S_STK_A, 0);
      step(0, 1, 0, 0, 0, 4'h0);
      chk("hltd_pen", S_PEN_A, 0); chk("hltd_stk", S_STK_A, 1); chk("hltd_miso", S_MISO_A, 1);
      chk("hltd_rc", S_RC_A, 5);
      step(0, 1, 0, 0, 0, 4'h0); chk("hltd_miso2", S_MISO_A, 1); chk("hltd_pen2", S_PEN_A, 0);
      step(0, 1, 1, 0, 0, 4'h0); chk("hltd_miso3", S_MISO_A, 1);
      step(0, 1, 1, 0, 0, 4'h0);
      chk("post_miso", S_MISO_A, 0); chk("post_stk", S_STK_A, 1); chk("post_rc", S_RC_A, 5);
      chk("post_rc_b", S_RC_B, 5); chk("post_stk_b", S_STK_B, 1);

      // Scan to chain 0 clears the sticky halt on its first shift.
      step(0, 0, 1, 0, 0, 4'h0);
      step(0, 0, 1, 0, 0, 4'h0);
      step(0, 0, 1, 0, 0, 4'h0); chk("sel_stk", S_STK_A, 1);
      step(0, 0, 1, 0, 0, 4'b0001);
      chk("c0_en", S_EN_A, 4'b0001); chk("c0_stk1", S_STK_A, 1); chk("c0_miso", S_MISO_A, 1);
      step(0, 0, 1, 1, 0, 4'b0000);
      chk("c0_stk0", S_STK_A, 0); chk("c0_en2", S_EN_A, 4'b0001); chk("c0_miso2", S_MISO_A, 0);
      step(0, 1, 1, 0, 0, 4'h0); chk("c0_cnt", S_SC_A, 2);
      step(0, 1, 1, 0, 0, 4'h0);

      // Both selects low from idle: scan wins.
      step(0, 0, 0, 0, 0, 4'h0); chk("both_pen0", S_PEN_A, 0);
      step(0, 0, 0, 0, 0, 4'h0); chk("both_pen1", S_PEN_A, 0);
      step(0, 0, 0, 1, 0, 4'h0); chk("both_pen2", S_PEN_A, 0);
      step(0, 0, 0, 1, 0, 4'b0010);
      chk("both_en", S_EN_A, 4'b0010); chk("both_pen3", S_PEN_A, 0); chk("both_miso", S_MISO_A, 1);
      step(0, 1, 1, 0, 0, 4'h0);
      step(0, 1, 1, 0, 0, 4'h0); chk("hold_rc", S_RC_A, 5);

      // Scan select during run aborts to WAIT.
      step(0, 1, 0, 0, 0, 4'h0);
      step(0, 1, 0, 0, 0, 4'h0); chk("ab_pen1", S_PEN_A, 1); chk("ab_rc0", S_RC_A, 0);
      step(0, 0, 0, 0, 0, 4'h0); chk("ab_pen0", S_PEN_A, 0); chk("ab_pen_b", S_PEN_B, 0);
      step(0, 0, 0, 0, 0, 4'h0);
      chk("ab_wait_pen", S_PEN_A, 0); chk("ab_en", S_EN_A, 0); chk("ab_rc1", S_RC_A, 1);
      chk("ab_miso", S_MISO_A, 0);
      repeat (3) begin
         step(0, 1, 0, 0, 0, 4'h0); chk("ab_hold_pen", S_PEN_A, 0);
      end
      step(0, 1, 1, 0, 0, 4'h0);
      step(0, 1, 1, 0, 0, 4'h0);

      // 20-bit shift: dut_b saturates at 15.
      step(0, 0, 1, 0, 0, 4'h0);
      step(0, 0, 1, 1, 0, 4'h0);
      step(0, 0, 1, 0, 0, 4'h0);
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1, 1'(i), 0, 4'h0);
         chk("sat_cnt_a", S_SC_A, i); chk("sat_cnt_b", S_SC_B, (i > 15) ? 15 : i);
      end
      step(0, 1, 1, 0, 0, 4'h0); chk("sat_end_a", S_SC_A, 20); chk("sat_end_b", S_SC_B, 15);
      step(0, 1, 1, 0, 0, 4'h0);

      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
